// File: rtl/seven_segment_capture.sv
// Captures four multiplexed seven-segment digits into BCD frames with per-digit decode errors.
// Optional stale-display timeout is built when SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN is defined.
module seven_segment_capture #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       segA,
  input  logic       segB,
  input  logic       segC,
  input  logic       segD,
  input  logic       segE,
  input  logic       segF,
  input  logic       segG,
  input  logic       dsen1,
  input  logic       dsen2,
  input  logic       dsen3,
  input  logic       dsen4,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] bcd4,
  output logic       frame_valid,
  output logic [3:0] seg_err,
  output logic       stale
);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 65535) begin : g_chk_settle
    $error("SETTLE_CYCLES out of range 2..65535");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 16777215) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES out of range 2..2^24-1");
  end

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Segment vector is ordered A..G from MSB to LSB, matching the decode table.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: f_decode = {1'b1, 4'h0};
      7'b0110000: f_decode = {1'b1, 4'h1};
      7'b1101101: f_decode = {1'b1, 4'h2};
      7'b1111001: f_decode = {1'b1, 4'h3};
      7'b0110011: f_decode = {1'b1, 4'h4};
      7'b1011011: f_decode = {1'b1, 4'h5};
      7'b1011111: f_decode = {1'b1, 4'h6};
      7'b1110000: f_decode = {1'b1, 4'h7};
      7'b1111111: f_decode = {1'b1, 4'h8};
      7'b1111011: f_decode = {1'b1, 4'h9};
      7'b1110111: f_decode = {1'b1, 4'hA};
      7'b0011111: f_decode = {1'b1, 4'hB};
      7'b1001110: f_decode = {1'b1, 4'hC};
      7'b0111101: f_decode = {1'b1, 4'hD};
      7'b1001111: f_decode = {1'b1, 4'hE};
      7'b1000111: f_decode = {1'b1, 4'hF};
      default:    f_decode = 5'b0_0000;
    endcase
  endfunction

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Stage p0/p1: two-flop synchronizer on all eleven display lines.
  logic [10:0] w_raw;
  logic [10:0] r_sync_p0;
  logic [10:0] r_sync_p1;
  logic [3:0]  w_en;

  assign w_raw = {dsen4, dsen3, dsen2, dsen1, segA, segB, segC, segD, segE, segF, segG};

  always_ff @(posedge clk_50mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end
  assign w_en = r_sync_p1[10:7];

  logic w_sel_valid;
  always_comb begin
    case (w_en)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_sel_valid = 1'b1;
      default:                            w_sel_valid = 1'b0;
    endcase
  end

  // Settle FSM: a digit is captured once per enable window after a stable run.
  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_snap;
  logic [15:0] r_cnt;
  logic        w_load;
  logic        w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_state_nxt = SETTLE;
          w_load      = 1'b1;
        end
      end
      SETTLE: begin
        if (!w_sel_valid) begin
          w_state_nxt = IDLE;
        end else if (r_sync_p1 != r_snap) begin
          w_load = 1'b1;
        end else if (r_cnt == SETTLE_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (w_en != r_snap[10:7]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_snap <= r_sync_p1;
        r_cnt  <= 16'd1;
      end else if (r_state == SETTLE && w_sel_valid) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Staging: per-digit value/error plus a mask of digits seen this frame.
  logic [4:0]      w_dec;
  logic [3:0]      w_dig_sel;
  logic [3:0][3:0] r_stg;
  logic [3:0]      r_stg_err;
  logic [3:0]      r_mask;
  logic            w_frame_done;

  assign w_dec        = f_decode(r_snap[6:0]);
  assign w_dig_sel    = ~r_snap[10:7];
  assign w_frame_done = (r_mask == 4'hF);

  always_ff @(posedge clk_50mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_stg     <= '0;
      r_stg_err <= '0;
      r_mask    <= '0;
    end else begin
      if (w_capture) begin
        for (int i = 0; i < 4; i++) begin
          if (w_dig_sel[i]) begin
            if (w_dec[4]) begin
              r_stg[i]     <= w_dec[3:0];
              r_stg_err[i] <= 1'b0;
            end else begin
              r_stg_err[i] <= 1'b1;
            end
          end
        end
      end
      r_mask <= (w_frame_done ? 4'h0 : r_mask) | (w_capture ? w_dig_sel : 4'h0);
    end
  end

  // Output stage: publish a completed frame one cycle after the mask fills.
  logic [3:0][3:0] r_bcd;
  logic [3:0]      r_err_out;
  logic            r_fv;

  always_ff @(posedge clk_50mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bcd     <= '0;
      r_err_out <= '0;
      r_fv      <= 1'b0;
    end else begin
      r_fv <= w_frame_done;
      if (w_frame_done) begin
        r_bcd     <= r_stg;
        r_err_out <= r_stg_err;
      end
    end
  end

  assign bcd1        = r_bcd[0];
  assign bcd2        = r_bcd[1];
  assign bcd3        = r_bcd[2];
  assign bcd4        = r_bcd[3];
  assign seg_err     = r_err_out;
  assign frame_valid = r_fv;

`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
  localparam logic [23:0] TO_MAX = 24'(TIMEOUT_CYCLES);
  logic [23:0] r_to_cnt;
  logic        r_stale;

  always_ff @(posedge clk_50mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (w_capture) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 24'd1;
      r_stale  <= (r_to_cnt + 24'd1 == TO_MAX);
    end
  end
  assign stale = r_stale;
`else
  assign stale = 1'b0;
`endif

endmodule
